// File: rtl/lift_pkg.sv
// Shared types for the SCAN lift controller: FSM states, motor command codes and
// travel direction, plus a small direction helper.
package lift_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_DOOR = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    DOUT_UP   = 2'b00,
    DOUT_DOWN = 2'b01,
    DOUT_STAY = 2'b10
  } dout_e;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_e;

  function automatic dir_e flip_dir(input dir_e d);
    return (d == DIR_UP) ? DIR_DN : DIR_UP;
  endfunction

endpackage

// File: rtl/lift_call_reg.sv
// Latched hall-call bitmaps with set/clear ports and the ahead/behind reduction
// relative to a query floor and travel direction.
module lift_call_reg
  import lift_pkg::*;
#(
  parameter int NUM_FLOORS = 4,
  parameter int FW         = $clog2(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FW-1:0]         eval_floor,
  input  dir_e                  dir,
  input  logic [NUM_FLOORS-1:0] set_up,
  input  logic [NUM_FLOORS-1:0] set_dn,
  input  logic [NUM_FLOORS-1:0] clr_up,
  input  logic [NUM_FLOORS-1:0] clr_dn,
  output logic [NUM_FLOORS-1:0] pend_up,
  output logic [NUM_FLOORS-1:0] pend_dn,
  output logic                  ahead,
  output logic                  behind
);

  logic [NUM_FLOORS-1:0] up_q, dn_q, any_call;
  logic                  above, below;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      up_q <= '0;
      dn_q <= '0;
    end else begin
      // A fresh call for the floor being served this cycle must survive the clear.
      up_q <= (up_q & ~clr_up) | set_up;
      dn_q <= (dn_q & ~clr_dn) | set_dn;
    end
  end

  assign any_call = up_q | dn_q;

  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i > int'(eval_floor)) above = above | any_call[i];
      if (i < int'(eval_floor)) below = below | any_call[i];
    end
  end

  assign ahead   = (dir == DIR_UP) ? above : below;
  assign behind  = (dir == DIR_UP) ? below : above;
  assign pend_up = up_q;
  assign pend_dn = dn_q;

endmodule

// File: rtl/lift_scan_ctrl.sv
// SCAN-policy lift controller: FSM, shared travel/dwell counter and floor register.
// Define LIFT_DOOR_HOLD_EN to add the door_hold input that freezes the door dwell.
module lift_scan_ctrl
  import lift_pkg::*;
#(
  parameter int NUM_FLOORS   = 4,
  parameter int FLOOR_CYCLES = 8,
  parameter int DOOR_CYCLES  = 16,
  localparam int FW          = $clog2(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef LIFT_DOOR_HOLD_EN
  input  logic                  door_hold,
`endif
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [FW-1:0]         req_floor,
  input  logic                  req_dir,
  output logic                  req_err,
  output logic [1:0]            dout,
  output logic [FW-1:0]         cur_floor,
  output logic                  door_open,
  output logic                  done,
  output logic [NUM_FLOORS-1:0] pend_up,
  output logic [NUM_FLOORS-1:0] pend_dn
);

  localparam int MAXC = (FLOOR_CYCLES > DOOR_CYCLES) ? FLOOR_CYCLES : DOOR_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [FW-1:0] TOP_FLOOR = FW'(NUM_FLOORS - 1);

  state_e                state_q, state_d;
  dir_e                  dir_q, dir_d, req_dir_e;
  logic [FW-1:0]         floor_q, floor_d, eval_floor;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ready_q, err_q;
  logic                  xfer, legal, absorb, hold, move_term;
  logic                  ahead, behind, here_up, here_dn, here_dir, here_any;
  logic [NUM_FLOORS-1:0] req_hot, eval_hot, set_up, set_dn, clr_up, clr_dn;

  assign req_dir_e = dir_e'(req_dir);
  assign xfer      = req_valid && req_ready;
  assign legal     = (int'(req_floor) < NUM_FLOORS)
                  && !(req_dir_e == DIR_UP && req_floor == TOP_FLOOR)
                  && !(req_dir_e == DIR_DN && req_floor == '0);

  // At a floor-step the stop decision looks at the floor being arrived at.
  assign move_term = (state_q == ST_MOVE) && (cnt_q == CW'(FLOOR_CYCLES - 1));
  assign eval_floor = !move_term      ? floor_q
                    : (dir_q == DIR_UP) ? floor_q + FW'(1) : floor_q - FW'(1);

  assign req_hot  = NUM_FLOORS'(1) << req_floor;
  assign eval_hot = NUM_FLOORS'(1) << eval_floor;
  assign here_up  = pend_up[eval_floor];
  assign here_dn  = pend_dn[eval_floor];
  assign here_dir = (dir_q == DIR_UP) ? here_up : here_dn;
  assign here_any = here_up | here_dn;

  // A call the open door already serves is swallowed and simply restarts the dwell.
  assign absorb = xfer && legal && (state_q == ST_DOOR) && (req_floor == floor_q)
               && ((req_dir_e == dir_q) || !ahead);
  assign set_up = (xfer && legal && !absorb && req_dir_e == DIR_UP) ? req_hot : '0;
  assign set_dn = (xfer && legal && !absorb && req_dir_e == DIR_DN) ? req_hot : '0;

`ifdef LIFT_DOOR_HOLD_EN
  assign hold = door_hold;
`else
  assign hold = 1'b0;
`endif

  lift_call_reg #(.NUM_FLOORS(NUM_FLOORS), .FW(FW)) u_calls (
    .clk(clk), .rst_n(rst_n), .eval_floor(eval_floor), .dir(dir_q),
    .set_up(set_up), .set_dn(set_dn), .clr_up(clr_up), .clr_dn(clr_dn),
    .pend_up(pend_up), .pend_dn(pend_dn), .ahead(ahead), .behind(behind)
  );

  always_comb begin
    // NOTE: every combinational output is defaulted first so no path can infer a latch.
    state_d = state_q;
    floor_d = floor_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    clr_up  = '0;
    clr_dn  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (here_any) begin
          state_d = ST_DOOR;
          cnt_d   = '0;
          clr_up  = eval_hot;
          clr_dn  = eval_hot;
        end else if (ahead) begin
          state_d = ST_MOVE;
          cnt_d   = '0;
        end else if (behind) begin
          state_d = ST_MOVE;
          dir_d   = flip_dir(dir_q);
          cnt_d   = '0;
        end
      end
      ST_MOVE: begin
        if (move_term) begin
          floor_d = eval_floor;
          cnt_d   = '0;
          if (here_dir || (here_any && !ahead)) begin
            state_d = ST_DOOR;
            if (dir_q == DIR_UP || !ahead) clr_up = eval_hot;
            if (dir_q == DIR_DN || !ahead) clr_dn = eval_hot;
          end else if (!ahead) begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DOOR: begin
        if (absorb || hold) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(DOOR_CYCLES - 1)) begin
          cnt_d = '0;
          if (ahead) begin
            state_d = ST_MOVE;
          end else if (behind) begin
            state_d = ST_MOVE;
            dir_d   = flip_dir(dir_q);
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      floor_q <= '0;
      cnt_q   <= '0;
      dir_q   <= DIR_UP;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      floor_q <= floor_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      ready_q <= 1'b1;
      err_q   <= xfer && !legal;
    end
  end

  assign req_ready = ready_q;
  assign req_err   = err_q;
  assign cur_floor = floor_q;
  assign door_open = (state_q == ST_DOOR);
  assign dout      = (state_q != ST_MOVE) ? DOUT_STAY
                   : (dir_q == DIR_UP)    ? DOUT_UP : DOUT_DOWN;
  assign done      = ready_q && (state_q == ST_IDLE) && !(|pend_up) && !(|pend_dn);

endmodule

// File: tb/tb_lift_scan_ctrl.sv
// Self-checking bench for lift_scan_ctrl: a floor-level SCAN model predicts stops into a
// scoreboard that a monitor drains on every door opening; directed cases cover corner rules.
`timescale 1ns/1ps
module tb_lift_scan_ctrl;

  localparam int N  = 4;
  localparam int FC = 8;
  localparam int DC = 16;
  localparam int FW = $clog2(N);

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          req_valid = 1'b0, req_dir = 1'b0;
  logic [FW-1:0] req_floor = '0;
  logic          req_ready, req_err, door_open, done;
  logic [1:0]    dout;
  logic [FW-1:0] cur_floor;
  logic [N-1:0]  pend_up, pend_dn;
`ifdef LIFT_DOOR_HOLD_EN
  logic          door_hold = 1'b0;
`endif

  always #5 clk = ~clk;

  lift_scan_ctrl #(.NUM_FLOORS(N), .FLOOR_CYCLES(FC), .DOOR_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef LIFT_DOOR_HOLD_EN
    .door_hold(door_hold),
`endif
    .req_valid(req_valid), .req_ready(req_ready), .req_floor(req_floor), .req_dir(req_dir),
    .req_err(req_err), .dout(dout), .cur_floor(cur_floor), .door_open(door_open),
    .done(done), .pend_up(pend_up), .pend_dn(pend_dn)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct { int floor; int travel; } stop_t;
  stop_t sb_q[$];
  bit    err_q[$];
  int    bf[$];
  bit    bd[$];
  int    m_floor = 0;
  bit    m_dir   = 1'b0;       // 0 = up, 1 = down
  bit    mon_en  = 1'b0;
  bit    door_prev = 1'b0, xfer_seen = 1'b0;
  int    mv_cnt = 0, dw_cnt = 0;

  function automatic bit is_illegal(input int f, input bit d);
    return (f >= N) || (!d && f == N - 1) || (d && f == 0);
  endfunction

  // Stop monitor: every door opening must match the next predicted stop.
  always @(negedge clk) begin
    stop_t s;
    if (mon_en) begin
      if (dout != 2'b10) mv_cnt++;
      if (door_open && !door_prev) begin
        if (sb_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_stop: door opened at floor %0d, none expected", cur_floor);
        end else begin
          s = sb_q.pop_front();
          check("stop_floor", cur_floor, s.floor);
          check("travel_cycles", mv_cnt, s.travel);
        end
        mv_cnt = 0;
        dw_cnt = 0;
      end
      if (door_open) dw_cnt++;
      if (!door_open && door_prev) check("dwell_cycles", dw_cnt, DC);
    end
    door_prev = door_open;
  end

  // Error monitor: req_err must pulse exactly one cycle after each illegal transfer.
  always @(posedge clk) xfer_seen = req_valid && req_ready;
  always @(negedge clk) begin
    bit e;
    if (rst_n) begin
      e = 1'b0;
      if (xfer_seen && err_q.size() != 0) e = err_q.pop_front();
      check("req_err", req_err, e);
    end
  end

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic issue(input int f, input bit d);
    req_valid = 1'b1;
    req_floor = FW'(f);
    req_dir   = d;
    err_q.push_back(is_illegal(f, d));
    sync();
    req_valid = 1'b0;
  endtask

  task automatic wait_door(input int bound);
    for (int k = 0; k < bound && !door_open; k++) @(negedge clk);
    check("door_reached", door_open, 1);
  endtask

  // Floor-level SCAN model over the batch's static call set.
  task automatic predict();
    bit up[N], dn[N];
    int first, pos, travel;
    bit d, beyond, hdir, hany, left;
    for (int k = 0; k < N; k++) begin up[k] = 0; dn[k] = 0; end
    first = -1;
    foreach (bf[i]) if (!is_illegal(bf[i], bd[i])) begin
      if (bd[i]) dn[bf[i]] = 1; else up[bf[i]] = 1;
      if (first < 0) first = bf[i];
    end
    if (first < 0) return;
    pos = m_floor;
    d   = m_dir;
    if (d ? (first > pos) : (first < pos)) d = ~d;
    travel = 0;
    for (int g = 0; g < 64; g++) begin
      pos = d ? pos - 1 : pos + 1;
      travel++;
      if (pos < 0 || pos >= N) break;
      beyond = 0;
      for (int k = 0; k < N; k++)
        if (d ? (k < pos) : (k > pos)) beyond |= up[k] | dn[k];
      hdir = d ? dn[pos] : up[pos];
      hany = up[pos] | dn[pos];
      if (hdir || (hany && !beyond)) begin
        sb_q.push_back(stop_t'{pos, travel * FC});
        travel = 0;
        if (d) dn[pos] = 0; else up[pos] = 0;
        if (!beyond) begin up[pos] = 0; dn[pos] = 0; end
        left = 0;
        for (int k = 0; k < N; k++) left |= up[k] | dn[k];
        if (!left) break;
        if (!beyond) d = ~d;
      end
    end
    m_floor = pos;
    m_dir   = d;
  endtask

  task automatic run_batch();
    int k;
    predict();
    sync();
    mv_cnt = 0;
    mon_en = 1'b1;
    foreach (bf[i]) issue(bf[i], bd[i]);
    repeat (3) @(negedge clk);
    for (k = 0; k < 3000 && !(done && sb_q.size() == 0); k++) @(negedge clk);
    check("batch_done", done, 1);
    check("batch_sb_empty", sb_q.size(), 0);
    check("batch_floor", cur_floor, m_floor);
    check("batch_pend_up", pend_up, 0);
    check("batch_pend_dn", pend_dn, 0);
    sb_q.delete();
    bf.delete();
    bd.delete();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    // Reset state while rst_n is held low
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_floor", cur_floor, 0);
    check("rst_dout", dout, 2'b10);
    check("rst_door", door_open, 0);
    check("rst_ready", req_ready, 0);
    check("rst_err", req_err, 0);
    check("rst_done", done, 0);
    check("rst_pend", {pend_up, pend_dn}, 0);
    sync();
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    check("ready_after_rst", req_ready, 1);
    check("done_after_rst", done, 1);

    // Illegal calls: UP at top, DOWN at bottom
    sync();
    issue(N - 1, 1'b0);
    issue(0, 1'b1);
    repeat (3) @(negedge clk);
    check("illegal_pend_up", pend_up, 0);
    check("illegal_pend_dn", pend_dn, 0);
    check("illegal_done", done, 1);
    check("illegal_floor", cur_floor, 0);

    // Directed SCAN scenarios
    bf = '{2};    bd = '{1'b0};       run_batch();
    bf = '{0};    bd = '{1'b0};       run_batch();
    bf = '{3, 1}; bd = '{1'b1, 1'b0}; run_batch();
    bf = '{0, 2}; bd = '{1'b0, 1'b1}; run_batch();

    // Door at floor 1 going up: a new 1-UP call restarts the dwell and is never latched
    mon_en = 1'b0;
    sync();
    issue(1, 1'b0);
    m_floor = 1;
    m_dir   = 1'b0;
    wait_door(200);
    repeat (5) @(negedge clk);
    sync();
    issue(1, 1'b0);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!door_open) break;
      n++;
      if (pend_up[1]) begin
        n_cmp++; n_bad++;
        $display("FAIL absorb_bit: pend_up[1] got 1, expected 0");
      end
    end
    check("absorb_dwell", n, DC);
    check("absorb_pend", {pend_up, pend_dn}, 0);
    check("absorb_floor", cur_floor, 1);

`ifdef LIFT_DOOR_HOLD_EN
    sync();
    issue(3, 1'b1);
    m_floor = 3;
    wait_door(300);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      if (!door_open) break;
      n++;
      if (k == 0)  door_hold = 1'b1;
      if (k == 40) door_hold = 1'b0;
      @(negedge clk);
    end
    door_hold = 1'b0;
    check("hold_dwell", n, 40 + DC);
`endif

    // Randomized batches against the model
    for (int b = 0; b < 30; b++) begin
      int cnt, f;
      bit d;
      cnt = $urandom_range(1, 5);
      for (int j = 0; j < cnt; j++) begin
        d = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 5) == 0) begin
          f = d ? 0 : N - 1;
        end else begin
          do f = $urandom_range(0, N - 1);
          while (f == m_floor || is_illegal(f, d));
        end
        bf.push_back(f);
        bd.push_back(d);
      end
      run_batch();
    end

    // Reset in the middle of travel
    mon_en = 1'b0;
    sync();
    if (m_floor >= 2) issue(0, 1'b0); else issue(3, 1'b1);
    repeat (6) @(negedge clk);
    check("moving_before_rst", dout != 2'b10, 1);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    check("midrst_floor", cur_floor, 0);
    check("midrst_dout", dout, 2'b10);
    check("midrst_pend", {pend_up, pend_dn}, 0);
    check("midrst_door", door_open, 0);
    check("midrst_ready", req_ready, 0);
    sync();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
